// File: rtl/key_event_pkg.sv
// Shared definitions for the key event counter: edge-select encodings
// and the helper that decides whether a debounced transition is reportable.
package key_event_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_t;

  // True when a transition towards new_lvl is selected by sel.
  function automatic logic edge_hit(input edge_t sel, input logic new_lvl);
    logic hit;
    case (sel)
      EDGE_NONE: hit = 1'b0;
      EDGE_RISE: hit = new_lvl;
      EDGE_FALL: hit = ~new_lvl;
      EDGE_BOTH: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchronizer, debounce filter and edge detector.
// evt pulses one cycle after the debounced level changes, if the change
// matches the edge select sampled at that moment.
module key_debounce
  import key_event_pkg::*;
#(
  parameter int DB_CYCLES = 16,
  parameter int IDLE_LVL  = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  key,
  input  edge_t edge_sel,
  output logic  evt
);

  localparam int  DBW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic IDLE = 1'(IDLE_LVL);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic           sync1_r;
  logic           sync2_r;
  logic           db_r;
  logic           db_d_r;
  logic [DBW-1:0] db_cnt_r;
  logic           evt_r;

  // Synchronize, filter level changes and register the accepted edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r  <= IDLE;
      sync2_r  <= IDLE;
      db_r     <= IDLE;
      db_d_r   <= IDLE;
      db_cnt_r <= {DBW{1'b0}};
      evt_r    <= 1'b0;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
      // Any sample equal to the held level restarts the stability count.
      if (sync2_r != db_r) begin
        if (db_cnt_r == DB_LAST) begin
          db_r     <= sync2_r;
          db_cnt_r <= {DBW{1'b0}};
        end else begin
          db_cnt_r <= db_cnt_r + DBW'(1);
        end
      end else begin
        db_cnt_r <= {DBW{1'b0}};
      end
      db_d_r <= db_r;
      evt_r  <= (db_r != db_d_r) && edge_hit(edge_sel, db_r);
    end
  end

  assign evt = evt_r;

endmodule

// File: rtl/key_event_counter.sv
// Multi-channel debounced key event counter.
// Optional feature: define KEY_EVENT_COUNTER_UPDOWN_EN to add the dir port
// (per-channel up/down counting). Without it every channel counts up.
// The per-channel edge select port is called type_sel because "type" is a
// reserved word in SystemVerilog.
module key_event_counter
  import key_event_pkg::*;
#(
  parameter int CH_NUM    = 4,
  parameter int CNT_WIDTH = 18,
  parameter int DB_CYCLES = 16,
  parameter int WRAP      = 1,
  parameter int IDLE_LVL  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CH_NUM-1:0]             key,
  input  logic [2*CH_NUM-1:0]           type_sel,
  input  logic [CH_NUM-1:0]             clr,
`ifdef KEY_EVENT_COUNTER_UPDOWN_EN
  input  logic [CH_NUM-1:0]             dir,
`endif
  output logic [CH_NUM-1:0]             evt,
  output logic [CH_NUM*CNT_WIDTH-1:0]   cnt,
  output logic [CH_NUM-1:0]             ovf
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CH_NUM-1:0] evt_s;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic [CNT_WIDTH-1:0] cnt_r;
      logic [CNT_WIDTH-1:0] cnt_nxt_s;
      logic                 ovf_r;
      logic                 ovf_nxt_s;
      logic                 up_s;

      key_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .IDLE_LVL  (IDLE_LVL)
      ) u_db (
        .clk      (clk),
        .rst_n    (rst_n),
        .key      (key[gi]),
        .edge_sel (edge_t'(type_sel[2*gi +: 2])),
        .evt      (evt_s[gi])
      );

`ifdef KEY_EVENT_COUNTER_UPDOWN_EN
      assign up_s = dir[gi];
`else
      assign up_s = 1'b1;
`endif

      // Next counter/flag value: clear wins, otherwise count the event with wrap or hold at the limit.
      always_comb begin
        cnt_nxt_s = cnt_r;
        ovf_nxt_s = ovf_r;
        if (clr[gi]) begin
          cnt_nxt_s = CNT_ZERO;
          ovf_nxt_s = 1'b0;
        end else if (evt_s[gi]) begin
          if (up_s) begin
            if (cnt_r == CNT_MAX) begin
              ovf_nxt_s = 1'b1;
              cnt_nxt_s = (WRAP != 0) ? CNT_ZERO : CNT_MAX;
            end else begin
              cnt_nxt_s = cnt_r + CNT_ONE;
            end
          end else begin
            if (cnt_r == CNT_ZERO) begin
              ovf_nxt_s = 1'b1;
              cnt_nxt_s = (WRAP != 0) ? CNT_MAX : CNT_ZERO;
            end else begin
              cnt_nxt_s = cnt_r - CNT_ONE;
            end
          end
        end else begin
          cnt_nxt_s = cnt_r;
          ovf_nxt_s = ovf_r;
        end
      end

      // Counter and sticky overflow flag registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_r <= CNT_ZERO;
          ovf_r <= 1'b0;
        end else begin
          cnt_r <= cnt_nxt_s;
          ovf_r <= ovf_nxt_s;
        end
      end

      assign cnt[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_r;
      assign ovf[gi] = ovf_r;
    end
  endgenerate

  assign evt = evt_s;

endmodule

// File: tb/tb_key_event_counter.sv
// Self-checking bench for key_event_counter: a wrapping and a saturating
// instance share stimulus; a window-based reference model predicts outputs.
module tb_key_event_counter;
  import key_event_pkg::*;

  localparam int CH   = 4;
  localparam int W    = 4;
  localparam int DB   = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [CH-1:0]     key;
  logic [2*CH-1:0]   type_sel;
  logic [CH-1:0]     clr;
  logic [CH-1:0]     dir_v;
  logic [CH-1:0]     evt_w, ovf_w, evt_s, ovf_s;
  logic [CH*W-1:0]   cnt_w, cnt_s;

  int tests  = 0;
  int failed = 0;

  key_event_counter #(.CH_NUM(CH), .CNT_WIDTH(W), .DB_CYCLES(DB), .WRAP(1), .IDLE_LVL(1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .key(key), .type_sel(type_sel), .clr(clr),
`ifdef KEY_EVENT_COUNTER_UPDOWN_EN
    .dir(dir_v),
`endif
    .evt(evt_w), .cnt(cnt_w), .ovf(ovf_w));

  key_event_counter #(.CH_NUM(CH), .CNT_WIDTH(W), .DB_CYCLES(DB), .WRAP(0), .IDLE_LVL(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .key(key), .type_sel(type_sel), .clr(clr),
`ifdef KEY_EVENT_COUNTER_UPDOWN_EN
    .dir(dir_v),
`endif
    .evt(evt_s), .cnt(cnt_s), .ovf(ovf_s));

  // Reference model: synchronized-sample history, debounced level, pending flip.
  bit hist [CH][0:DB];
  bit db_m [CH];
  bit fp_m [CH];
  bit fl_m [CH];     // level the pending flip went to
  bit evt_m[CH];
  int cnt_m[2][CH];  // [0] wrapping, [1] saturating
  bit ovf_m[2][CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k <= DB; k++) hist[c][k] = 1'b1;
      db_m[c] = 1'b1; fp_m[c] = 1'b0; fl_m[c] = 1'b0; evt_m[c] = 1'b0;
      for (int m = 0; m < 2; m++) begin cnt_m[m][c] = 0; ovf_m[m][c] = 1'b0; end
    end
  endfunction

  // Advance the model by one rising edge using the inputs held across it.
  function automatic void model_edge();
    for (int c = 0; c < CH; c++) begin
      bit up, all_diff;
      logic [1:0] sel;
      up = 1'b1;
`ifdef KEY_EVENT_COUNTER_UPDOWN_EN
      up = dir_v[c];
`endif
      for (int m = 0; m < 2; m++) begin
        if (clr[c]) begin
          cnt_m[m][c] = 0; ovf_m[m][c] = 1'b0;
        end else if (evt_m[c]) begin
          if (up) begin
            if (cnt_m[m][c] == MAXV) begin ovf_m[m][c] = 1'b1; cnt_m[m][c] = (m == 0) ? 0 : MAXV; end
            else cnt_m[m][c] = cnt_m[m][c] + 1;
          end else begin
            if (cnt_m[m][c] == 0) begin ovf_m[m][c] = 1'b1; cnt_m[m][c] = (m == 0) ? MAXV : 0; end
            else cnt_m[m][c] = cnt_m[m][c] - 1;
          end
        end
      end
      sel = type_sel[2*c +: 2];
      evt_m[c] = fp_m[c] && ((sel == 2'b11) || (sel == 2'b01 && fl_m[c]) || (sel == 2'b10 && !fl_m[c]));
      // Level accepted when the last DB synchronized samples all differ from it.
      all_diff = 1'b1;
      for (int k = 1; k <= DB; k++) if (hist[c][k] == db_m[c]) all_diff = 1'b0;
      fp_m[c] = all_diff;
      if (all_diff) begin fl_m[c] = hist[c][1]; db_m[c] = hist[c][1]; end
      for (int k = DB; k >= 1; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = key[c];
    end
  endfunction

  task automatic compare_all(input string ph);
    for (int c = 0; c < CH; c++) begin
      check($sformatf("%s evt_wrap[%0d]", ph, c), 32'(evt_w[c]), 32'(evt_m[c]));
      check($sformatf("%s evt_sat[%0d]", ph, c),  32'(evt_s[c]), 32'(evt_m[c]));
      check($sformatf("%s cnt_wrap[%0d]", ph, c), 32'(cnt_w[c*W +: W]), 32'(cnt_m[0][c]));
      check($sformatf("%s cnt_sat[%0d]", ph, c),  32'(cnt_s[c*W +: W]), 32'(cnt_m[1][c]));
      check($sformatf("%s ovf_wrap[%0d]", ph, c), 32'(ovf_w[c]), 32'(ovf_m[0][c]));
      check($sformatf("%s ovf_sat[%0d]", ph, c),  32'(ovf_s[c]), 32'(ovf_m[1][c]));
    end
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(ph);
  endtask

  // One clean press/release on channel c (falling then rising).
  task automatic press(input int c);
    key[c] = 1'b0;
    repeat (10) step("press");
    key[c] = 1'b1;
    repeat (10) step("release");
  endtask

  task automatic clear_ch(input int c);
    clr[c] = 1'b1;
    step("clr");
    clr[c] = 1'b0;
  endtask

  int  hold[CH];
  bit  seen;

  initial begin
    rst_n = 1'b0; key = '1; clr = '0; dir_v = '1;
    type_sel = {4{2'b10}};
    model_reset();
    #12;
    check("reset evt", 32'(evt_w | evt_s), 32'd0);
    check("reset cnt", 32'(cnt_w | cnt_s), 32'd0);
    check("reset ovf", 32'(ovf_w | ovf_s), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) step("idle");

    // Latency: falling key on ch0 -> evt at edge DB+3, count one edge later.
    key[0] = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      step("lat");
      check($sformatf("lat evt0 edge%0d", e), 32'(evt_w[0]), (e == 7) ? 32'd1 : 32'd0);
      if (e == 8) check("lat cnt0", 32'(cnt_w[W-1:0]), 32'd1);
    end
    key[0] = 1'b1;
    repeat (10) step("lat_rel");

    // Short glitch on ch1 is filtered.
    key[1] = 1'b0;
    repeat (3) step("glitch");
    key[1] = 1'b1;
    for (int e = 0; e < 12; e++) begin
      step("glitch");
      check("glitch evt1", 32'(evt_w[1]), 32'd0);
    end
    check("glitch cnt1", 32'(cnt_w[2*W-1:W]), 32'd0);

    // Limit behaviour: 17 events on ch0 in both modes.
    clear_ch(0);
    for (int ev = 1; ev <= 17; ev++) begin
      press(0);
      if (ev == 15) begin
        check("lim15 cnt_sat", 32'(cnt_s[W-1:0]), 32'd15);
        check("lim15 ovf_sat", 32'(ovf_s[0]), 32'd0);
      end
      if (ev == 16) begin
        check("lim16 cnt_sat", 32'(cnt_s[W-1:0]), 32'd15);
        check("lim16 ovf_sat", 32'(ovf_s[0]), 32'd1);
        check("lim16 cnt_wrap", 32'(cnt_w[W-1:0]), 32'd0);
        check("lim16 ovf_wrap", 32'(ovf_w[0]), 32'd1);
      end
      if (ev == 17) begin
        check("lim17 cnt_sat", 32'(cnt_s[W-1:0]), 32'd15);
        check("lim17 cnt_wrap", 32'(cnt_w[W-1:0]), 32'd1);
      end
    end

    // Clear coinciding with an event at count 5.
    clear_ch(0);
    repeat (5) press(0);
    check("clrhit cnt5", 32'(cnt_w[W-1:0]), 32'd5);
    key[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step("clrhit");
      if (evt_w[0]) seen = 1'b1;
    end
    check("clrhit evt seen", 32'(seen), 32'd1);
    clr[0] = 1'b1;
    step("clrhit");
    clr[0] = 1'b0;
    check("clrhit cnt0", 32'(cnt_w[W-1:0]), 32'd0);
    check("clrhit ovf0", 32'(ovf_w[0]), 32'd0);
    key[0] = 1'b1;
    repeat (10) step("clrhit_rel");

    // Asynchronous reset mid-debounce with count 9.
    repeat (9) press(0);
    check("rst cnt9", 32'(cnt_w[W-1:0]), 32'd9);
    key[0] = 1'b0;
    repeat (3) step("rst_mid");
    #2 rst_n = 1'b0; key[0] = 1'b1;
    model_reset();
    #1;
    check("async rst evt", 32'(evt_w | evt_s), 32'd0);
    check("async rst cnt", 32'(cnt_w | cnt_s), 32'd0);
    check("async rst ovf", 32'(ovf_w | ovf_s), 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      step("post_rst");
      check("post_rst evt", 32'(evt_w), 32'd0);
    end

`ifdef KEY_EVENT_COUNTER_UPDOWN_EN
    // Down count from zero wraps to all-ones and flags overflow.
    dir_v[0] = 1'b0;
    press(0);
    check("down cnt_wrap", 32'(cnt_w[W-1:0]), 32'(MAXV));
    check("down ovf_wrap", 32'(ovf_w[0]), 32'd1);
    check("down cnt_sat", 32'(cnt_s[W-1:0]), 32'd0);
    dir_v[0] = 1'b1;
`endif

    // Randomized traffic on all channels.
    for (int c = 0; c < CH; c++) hold[c] = $urandom_range(1, 9);
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          key[c] = ~key[c];
          hold[c] = $urandom_range(1, 9);
        end
        clr[c] = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 199) == 0) type_sel[2*c +: 2] = 2'($urandom_range(0, 3));
`ifdef KEY_EVENT_COUNTER_UPDOWN_EN
        if ($urandom_range(0, 99) == 0) dir_v[c] = ~dir_v[c];
`endif
      end
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
